// File: rtl/y86_run_sequencer.sv
// Y86-64 run controller: load imem, release CPU reset, run to HLT/fault/timeout, check registers; Y86_SEQ_STALL_DET_EN adds PC-stall abort.
// Latency: one byte per cycle in LOAD, RST_HOLD reset cycles, one table entry per cycle in CHECK; ld_ready_o is high only in LOAD.
module y86_run_sequencer #(
    parameter int IMEM_DEPTH  = 256,
    parameter int NUM_CHECKS  = 8,
    parameter int MAX_CYCLES  = 20,
    parameter int RST_HOLD    = 2,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 8,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int IW = $clog2(NUM_CHECKS)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             ld_valid_i,
    input  logic [7:0]       ld_data_i,
    input  logic             ld_last_i,
    output logic             ld_ready_o,
    output logic             imem_we_o,
    output logic [AW-1:0]    imem_addr_o,
    output logic [7:0]       imem_wdata_o,
    input  logic             exp_we_i,
    input  logic [IW-1:0]    exp_idx_i,
    input  logic [3:0]       exp_reg_i,
    input  logic [63:0]      exp_val_i,
    input  logic             exp_en_i,
    output logic             cpu_rst_n_o,
    input  logic [1:0]       cpu_stat_i,
    input  logic [63:0]      cpu_pc_i,
    output logic [3:0]       rf_raddr_o,
    input  logic [63:0]      rf_rdata_i,
    output logic             done_o,
    output logic             pass_o,
    output logic [2:0]       result_code_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [IW-1:0]    fail_idx_o
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [2:0] RC_PASS     = 3'd0;
    localparam logic [2:0] RC_MISMATCH = 3'd1;
    localparam logic [2:0] RC_ADR      = 3'd2;
    localparam logic [2:0] RC_INS      = 3'd3;
    localparam logic [2:0] RC_TIMEOUT  = 3'd4;
    localparam logic [2:0] RC_OVERFLOW = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HOLD, S_RUN, S_SETTLE, S_CHECK, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    fail_q, fail_d;
    logic [2:0]       code_q, code_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             run_q, run_d;

    logic [3:0]       exp_reg_q [NUM_CHECKS];
    logic [63:0]      exp_val_q [NUM_CHECKS];
    logic             exp_en_q  [NUM_CHECKS];

`ifdef Y86_SEQ_STALL_DET_EN
    localparam logic [2:0] RC_STALL = 3'd6;
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [63:0] pc_q, pc_d;
    logic [SW-1:0] stall_q, stall_d;
`else
    logic unused_pc;
    assign unused_pc = ^{cpu_pc_i, STALL_LIMIT[0]};
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        fail_d       = fail_q;
        code_d       = code_q;
        done_d       = done_q;
        pass_d       = pass_q;
        run_d        = run_q;
        ld_ready_o   = 1'b0;
        imem_we_o    = 1'b0;
        imem_addr_o  = '0;
        imem_wdata_o = '0;
        rf_raddr_o   = '0;
`ifdef Y86_SEQ_STALL_DET_EN
        pc_d         = pc_q;
        stall_d      = stall_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    fail_d  = '0;
                    code_d  = RC_PASS;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    run_d   = 1'b0;
                end
            end
            S_LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    imem_we_o    = 1'b1;
                    imem_addr_o  = addr_q;
                    imem_wdata_o = ld_data_i;
                    if (ld_last_i) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end else if (addr_q == AW'(IMEM_DEPTH - 1)) begin
                        // Image does not fit: abort with the CPU still in reset.
                        state_d = S_DONE;
                        code_d  = RC_OVERFLOW;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == HW'(RST_HOLD - 1)) begin
                    state_d = S_RUN;
                    run_d   = 1'b1;
`ifdef Y86_SEQ_STALL_DET_EN
                    stall_d = '0;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
`ifdef Y86_SEQ_STALL_DET_EN
                pc_d    = cpu_pc_i;
                stall_d = (stall_q != '0 && cpu_pc_i == pc_q) ? stall_q + 1'b1 : SW'(1);
`endif
                // HLT is tested first so it beats a simultaneous timeout.
                if (cpu_stat_i == STAT_HLT) begin
                    state_d = S_SETTLE;
                end else if (cpu_stat_i == STAT_ADR || cpu_stat_i == STAT_INS) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    code_d  = (cpu_stat_i == STAT_ADR) ? RC_ADR : RC_INS;
`ifdef Y86_SEQ_STALL_DET_EN
                end else if (stall_d == SW'(STALL_LIMIT)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    code_d  = RC_STALL;
`endif
                end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    code_d  = RC_TIMEOUT;
                end
            end
            S_SETTLE: begin
                state_d = S_CHECK;
                idx_d   = '0;
            end
            S_CHECK: begin
                rf_raddr_o = exp_reg_q[idx_q];
                if (exp_en_q[idx_q] && rf_rdata_i != exp_val_q[idx_q]) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    code_d  = RC_MISMATCH;
                    fail_d  = idx_q;
                end else if (idx_q == IW'(NUM_CHECKS - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    code_d  = RC_PASS;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            fail_q  <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            run_q   <= 1'b0;
`ifdef Y86_SEQ_STALL_DET_EN
            pc_q    <= '0;
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            run_q   <= run_d;
`ifdef Y86_SEQ_STALL_DET_EN
            pc_q    <= pc_d;
            stall_q <= stall_d;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_reg_q[i] <= '0;
                exp_val_q[i] <= '0;
                exp_en_q[i]  <= 1'b0;
            end
        end else if (exp_we_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            exp_reg_q[exp_idx_i] <= exp_reg_i;
            exp_val_q[exp_idx_i] <= exp_val_i;
            exp_en_q[exp_idx_i]  <= exp_en_i;
        end
    end

    assign cpu_rst_n_o   = run_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign result_code_o = code_q;
    assign cycle_count_o = cnt_q;
    assign fail_idx_o    = fail_q;

endmodule

// File: tb/tb_y86_run_sequencer.sv
// Directed bench for y86_run_sequencer with a tiny behavioural Y86 core (nop/halt/irmovq/addq/jmp/mrmovq).
// A second instance with IMEM_DEPTH=16 exercises load overflow.
module tb_y86_run_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, imem_we;
    logic [7:0]  imem_addr, imem_wdata;
    logic        exp_we = 1'b0, exp_en = 1'b0;
    logic [2:0]  exp_idx = '0;
    logic [3:0]  exp_reg = '0;
    logic [63:0] exp_val = '0;
    logic        cpu_rst_n;
    logic [1:0]  cpu_stat;
    logic [63:0] pc;
    logic [3:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic        done, pass;
    logic [2:0]  code, fail_idx;
    logic [15:0] cnt;

    y86_run_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ld_ready),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .exp_we_i(exp_we), .exp_idx_i(exp_idx), .exp_reg_i(exp_reg), .exp_val_i(exp_val), .exp_en_i(exp_en),
        .cpu_rst_n_o(cpu_rst_n), .cpu_stat_i(cpu_stat), .cpu_pc_i(pc),
        .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
        .done_o(done), .pass_o(pass), .result_code_o(code), .cycle_count_o(cnt), .fail_idx_o(fail_idx)
    );

    // small-memory instance
    logic        start_s = 1'b0, ld_valid_s = 1'b0;
    logic [7:0]  ld_data_s = '0;
    logic        ld_ready_s, imem_we_s, cpu_rst_n_s, done_s, pass_s;
    logic [3:0]  imem_addr_s, rf_raddr_s;
    logic [7:0]  imem_wdata_s;
    logic [2:0]  code_s, fail_idx_s;
    logic [15:0] cnt_s;

    y86_run_sequencer #(.IMEM_DEPTH(16)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s),
        .ld_valid_i(ld_valid_s), .ld_data_i(ld_data_s), .ld_last_i(1'b0), .ld_ready_o(ld_ready_s),
        .imem_we_o(imem_we_s), .imem_addr_o(imem_addr_s), .imem_wdata_o(imem_wdata_s),
        .exp_we_i(1'b0), .exp_idx_i(3'd0), .exp_reg_i(4'd0), .exp_val_i(64'd0), .exp_en_i(1'b0),
        .cpu_rst_n_o(cpu_rst_n_s), .cpu_stat_i(2'b00), .cpu_pc_i(64'd0),
        .rf_raddr_o(rf_raddr_s), .rf_rdata_i(64'd0),
        .done_o(done_s), .pass_o(pass_s), .result_code_o(code_s), .cycle_count_o(cnt_s), .fail_idx_o(fail_idx_s)
    );

    logic rose_s = 1'b0;
    always @(posedge clk) rose_s <= rose_s | cpu_rst_n_s;

    // behavioural CPU
    logic [7:0]  imem [256];
    logic [63:0] regs [16];
    logic [7:0]  op, b1;
    logic [63:0] imm2;
    int          we_cnt = 0;

    function automatic logic [63:0] rd64(input logic [7:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = imem[a + 8'(i)];
        return r;
    endfunction

    always_comb begin
        op       = imem[pc[7:0]];
        b1       = imem[pc[7:0] + 8'd1];
        imm2     = rd64(pc[7:0] + 8'd2);
        cpu_stat = 2'b00;
        if (pc > 64'd255) cpu_stat = 2'b10;
        else case (op)
            8'h00, 8'h30, 8'h60, 8'h70: cpu_stat = 2'b00;
            8'h10: cpu_stat = 2'b01;
            8'h50: cpu_stat = (((b1[3:0] == 4'hF) ? 64'd0 : regs[b1[3:0]]) + imm2 > 64'd255) ? 2'b10 : 2'b00;
            default: cpu_stat = 2'b11;
        endcase
    end

    always @(posedge clk) begin
        if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (!cpu_rst_n) begin
            pc <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (cpu_stat == 2'b00) begin
            case (op)
                8'h30: begin regs[b1[3:0]] <= imm2; pc <= pc + 10; end
                8'h60: begin regs[b1[3:0]] <= regs[b1[3:0]] + regs[b1[7:4]]; pc <= pc + 2; end
                8'h70: pc <= rd64(pc[7:0] + 8'd1);
                8'h50: begin regs[b1[7:4]] <= '0; pc <= pc + 10; end
                default: pc <= pc + 1;
            endcase
        end
    end

    assign rf_rdata = regs[rf_raddr];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] prog [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic exp_write(input int idx, input int r, input logic [63:0] v, input logic en);
        exp_we = 1'b1; exp_idx = 3'(idx); exp_reg = 4'(r); exp_val = v; exp_en = en;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic load_prog();
        check("ld_ready_in_load", ld_ready, 1);
        for (int i = 0; i < prog.size(); i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == prog.size() - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && !done; i++) tick();
        check(tag, done, 1);
    endtask

    task automatic set_prog1();
        prog = {8'h30, 8'hF0, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h30, 8'hF3, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h60, 8'h30,
                8'h30, 8'hF4, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h10};
    endtask

    task automatic set_table1();
        exp_write(0, 0, 64'd30, 1'b1);
        exp_write(1, 3, 64'd20, 1'b1);
        exp_write(2, 4, 64'd100, 1'b1);
    endtask

    initial begin
        int we0;
        #1;
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_code", code, 0);
        check("rst_cnt", cnt, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_imem_we", imem_we, 0);
        #11 rst_n = 1'b1;
        tick();

        // program 1: expect PASS after 5 cycles
        set_table1();
        set_prog1();
        do_start();
        we0 = we_cnt;
        load_prog();
        check("p1_cpu_held", cpu_rst_n, 0);
        wait_done("p1_done");
        check("p1_pass", pass, 1);
        check("p1_code", code, 0);
        check("p1_cnt", cnt, 5);
        check("p1_we_count", 64'(we_cnt - we0), 33);
        check("p1_cpu_released", cpu_rst_n, 1);

        // wrong rax; a table write while busy must be ignored
        exp_write(0, 0, 64'd31, 1'b1);
        do_start();
        load_prog();
        exp_write(0, 0, 64'd30, 1'b1);
        wait_done("mm_done");
        check("mm_code", code, 1);
        check("mm_fail_idx", fail_idx, 0);
        check("mm_pass", pass, 0);
        exp_write(0, 0, 64'd30, 1'b1);

        // 40 nops: timeout
        prog.delete();
        repeat (40) prog.push_back(8'h00);
        do_start();
        check("start_clears_done", done, 0);
        load_prog();
        wait_done("to_done");
        check("to_code", code, 4);
        check("to_cnt", cnt, 20);

        // illegal opcode
        prog = {8'hF0};
        do_start();
        load_prog();
        wait_done("ins_done");
        check("ins_code", code, 3);
        check("ins_cnt", cnt, 1);

        // mrmovq from 0x1000: address error
        prog = {8'h50, 8'h0F, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start();
        load_prog();
        wait_done("adr_done");
        check("adr_code", code, 2);
        check("adr_cnt", cnt, 1);

        // overflow on 16-byte memory
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_valid_s = 1'b1;
            ld_data_s  = 8'(i);
            tick();
        end
        check("ovf_done", done_s, 1);
        check("ovf_code", code_s, 5);
        tick();
        check("ovf_ready_low", ld_ready_s, 0);
        ld_valid_s = 1'b0;
        check("ovf_cpu_never_released", rose_s, 0);

        // async reset in the middle of RUN
        prog.delete();
        repeat (10) prog.push_back(8'h00);
        do_start();
        load_prog();
        for (int i = 0; i < 20 && !cpu_rst_n; i++) tick();
        tick();
        tick();
        check("mid_run_cnt_nonzero", 64'(cnt != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cpu_rst_n", cpu_rst_n, 0);
        check("arst_cnt", cnt, 0);
        check("arst_done", done, 0);
        check("arst_code", code, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        set_table1();
        set_prog1();
        do_start();
        load_prog();
        wait_done("rerun_done");
        check("rerun_pass", pass, 1);
        check("rerun_code", code, 0);

        // jmp-to-self at 0x00
        prog = {8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start();
        load_prog();
        wait_done("jmp_done");
`ifdef Y86_SEQ_STALL_DET_EN
        check("stall_code", code, 6);
        check("stall_cnt", cnt, 8);
`else
        check("jmp_code", code, 4);
        check("jmp_cnt", cnt, 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/y86_run_sequencer.md
Name: y86_run_sequencer

Overview:
Synthesizable, parametrised run controller for the Y86-64 single-cycle CPU. It streams a program into instruction memory, holds and then releases the CPU reset, and counts cycles while watching stat. It stops on HLT, ADR, INS or timeout, then checks a table of expected register values against the register file. Sits beside y86_cpu in both the FPGA bring-up top and the regression bench, replacing hand-written per-test checking.

Parameters:
IMEM_DEPTH, 256, instruction memory bytes; address width AW = clog2(IMEM_DEPTH)
NUM_CHECKS, 8, expected-value table entries; index width IW = clog2(NUM_CHECKS)
MAX_CYCLES, 20, RUN cycles before timeout
RST_HOLD, 2, cycles cpu_rst_n_o stays low after load
CNT_W, 16, cycle counter width
STALL_LIMIT, 8, consecutive cycles with unchanged PC counted as a stall (optional feature only)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  begin run; pulse
ld_valid_i  in  1  program byte valid
ld_data_i  in  8  program byte
ld_last_i  in  1  final program byte
ld_ready_o  out  1  byte accepted when valid&&ready
imem_we_o  out  1  instruction memory write enable
imem_addr_o  out  AW  write address
imem_wdata_o  out  8  write data
exp_we_i  in  1  write expected-table entry
exp_idx_i  in  IW  entry index
exp_reg_i  in  4  register id
exp_val_i  in  64  expected value
exp_en_i  in  1  entry enable
cpu_rst_n_o  out  1  CPU reset, active-low
cpu_stat_i  in  2  CPU stat: 00 AOK, 01 HLT, 10 ADR, 11 INS
cpu_pc_i  in  64  CPU PC
rf_raddr_o  out  4  register file read address (combinational read)
rf_rdata_i  in  64  register file read data
done_o  out  1  run finished; held until next start
pass_o  out  1  valid when done_o
result_code_o  out  3  0 PASS, 1 REG_MISMATCH, 2 ADR, 3 INS, 4 TIMEOUT, 5 LOAD_OVERFLOW, 6 STALL
cycle_count_o  out  CNT_W  RUN cycles executed
fail_idx_o  out  IW  first failing entry

Behaviour:
- Reset is asynchronous and forces all of the following; every output is 0 and cpu_rst_n_o is 0 immediately:
  - state goes to IDLE;
  - the expected-table enables are cleared;
  - all outputs (cpu_rst_n_o included) are driven to 0.
- FSM states: IDLE, LOAD, HOLD, RUN, SETTLE, CHECK, DONE.
- IDLE/DONE:
  - start_i clears done_o, pass_o, result_code_o, cycle_count_o, fail_idx_o and the load address, then moves to LOAD.
  - start_i in any other state is ignored.
- LOAD:
  - ld_ready_o=1. Each accepted byte drives imem_we_o=1, imem_addr_o=current address, imem_wdata_o=the byte, all in the same cycle; the address then increments.
  - An accepted byte with ld_last_i moves to HOLD.
  - A byte accepted at address IMEM_DEPTH-1 without ld_last_i moves to DONE with LOAD_OVERFLOW; the address does not wrap.
  - cpu_rst_n_o stays 0 throughout.
- HOLD: cpu_rst_n_o=0 for RST_HOLD cycles, then it goes 1 and the FSM enters RUN.
- RUN:
  - Each cycle increments cycle_count_o. cpu_stat_i is sampled on the same edge, after the increment.
  - HLT moves to SETTLE. ADR or INS moves to DONE with code 2 or 3.
  - If cycle_count_o reaches MAX_CYCLES with stat AOK, move to DONE with TIMEOUT.
  - HLT and the timeout on the same edge: HLT wins.
- SETTLE: one cycle for the final write-back to land, then CHECK.
- CHECK:
  - Scans entries 0..NUM_CHECKS-1, one per cycle; disabled entries take a cycle but are skipped.
  - rf_raddr_o=exp_reg of the current entry; rf_rdata_i is compared to exp_val in that same cycle.
  - The first mismatch moves to DONE with REG_MISMATCH and fail_idx_o=the entry index.
  - When the scan completes, move to DONE with PASS. A table with no entries enabled passes.
- DONE: done_o=1; pass_o=1 only when the code is PASS; cpu_rst_n_o stays 1 (so the CPU stays halted and the register file stays readable).
- exp_we_i is honoured only in IDLE and DONE; it is ignored elsewhere.
- cycle_count_o never exceeds MAX_CYCLES.

Optional Feature:
Y86_SEQ_STALL_DET_EN
- Defined: in RUN, if cpu_pc_i stays unchanged for STALL_LIMIT consecutive cycles with stat AOK, move to DONE with STALL (code 6). The counter restarts at any PC change.
- Undefined: no PC tracking logic; code 6 is never produced; cpu_pc_i is unused.

Test Plan:
- Load 33 bytes at 0x00-0x20:
  - 30F00A00000000000000 — irmovq $10,%rax
  - 30F31400000000000000 — irmovq $20,%rbx
  - 6030 — addq %rbx,%rax
  - 30F46400000000000000 — irmovq $100,%rsp
  - 10 — halt, with ld_last_i
  - Expected table rax=30, rbx=20, rsp=100 -> done_o=1, pass_o=1, code 0, cycle_count_o=5, imem_we_o asserted 33 times.
- Same program, expected rax=31 in entry 0 -> code 1, fail_idx_o=0, pass_o=0.
- 40 bytes of 0x00 (nop) with MAX_CYCLES=20 -> code 4, cycle_count_o=20.
- First byte 0xF0 -> code 3, cycle_count_o=1; separately, run an ADR-producing program -> code 2.
- IMEM_DEPTH=16, stream 17 bytes with no ld_last_i -> code 5 after the 16th byte accepted; ld_ready_o=0 afterwards; cpu_rst_n_o never rises.
- Drop rst_n_i mid-RUN -> all outputs 0 asynchronously; then start_i plus a reload of the first program -> PASS. With Y86_SEQ_STALL_DET_EN, jmp-to-self at 0x00 -> code 6 at cycle 8.
